// File: rtl/jpeg_pkg.sv
// Shared JPEG pipeline types: block/format tags, framebuffer writer states and
// the framebuffer address helper.
package jpeg_pkg;

  typedef enum logic [1:0] {
    BLK_Y  = 2'd0,
    BLK_CB = 2'd1,
    BLK_CR = 2'd2
  } block_type_e;

  typedef enum logic [1:0] {
    FMT_MONO   = 2'd0,
    FMT_YUV420 = 2'd1,
    FMT_YUV422 = 2'd2,
    FMT_YUV444 = 2'd3
  } jpeg_format_e;

  typedef enum logic [2:0] {
    FBW_IDLE      = 3'd0,
    FBW_START     = 3'd1,
    FBW_WAIT_BUSY = 3'd2,
    FBW_RUN       = 3'd3,
    FBW_DRAIN     = 3'd4,
    FBW_ABORT     = 3'd5
  } fbw_state_e;

  localparam int unsigned PIX_BYTES = 4;

  // Byte address of pixel (x,y); 32-bit arithmetic that wraps modulo 2^32.
  function automatic logic [31:0] fb_addr(input logic [31:0] base,
                                          input logic [15:0] stride,
                                          input logic [15:0] x,
                                          input logic [15:0] y);
    return base + (32'(y) * 32'(stride)) + (32'(x) * 32'(PIX_BYTES));
  endfunction

endpackage

// File: rtl/jpeg_fb_fifo.sv
// Show-ahead write buffer for the framebuffer writer. The flush input keeps
// only the head entry (so a request already on the bus can complete) and drops
// everything behind it.
module jpeg_fb_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2,
  parameter int unsigned W     = 64
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic [W-1:0]  data_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output logic [W-1:0]  data_o,
  output logic          empty_o,
  output logic          full_o,
  output logic [AW:0]   level_o
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   level;
  logic          do_push;
  logic          do_pop;

  assign empty_o = (level == '0);
  assign full_o  = (level == (AW+1)'(DEPTH));
  assign level_o = level;
  assign data_o  = mem[rd_ptr];
  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o;

  // Storage write; contents are qualified by level so no reset is needed.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= data_i;
  end

  // Pointer and level bookkeeping, with head-preserving flush.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else if (flush_i) begin
      if (do_pop || empty_o) begin
        rd_ptr <= rd_ptr + AW'(do_pop);
        wr_ptr <= rd_ptr + AW'(do_pop);
        level  <= '0;
      end else begin
        wr_ptr <= rd_ptr + AW'(1);
        level  <= (AW+1)'(1);
      end
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/jpeg_fb_writer.sv
// Frame-level framebuffer writer: starts a decode, consumes clipped pixels,
// buffers {addr,data} writes and reports completion once everything drained.
module jpeg_fb_writer
  import jpeg_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned FIFO_ADDR_W = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cfg_start_i,
  input  logic        cfg_abort_i,
  input  logic [31:0] cfg_base_i,
  input  logic [15:0] cfg_stride_i,
  output logic        img_start_o,
  input  logic        img_idle_i,
  input  logic        pix_v_i,
  input  logic [15:0] pix_x_i,
  input  logic [15:0] pix_y_i,
  input  logic [15:0] pix_width_i,
  input  logic [15:0] pix_height_i,
  input  logic [7:0]  pix_r_i,
  input  logic [7:0]  pix_g_i,
  input  logic [7:0]  pix_b_i,
  output logic        pix_yumi_o,
  output logic        mem_v_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  input  logic        mem_ready_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] wr_count_o,
  output logic [31:0] drop_count_o
);

  fbw_state_e           state;
  logic [31:0]          base;
  logic [15:0]          stride;
  logic [63:0]          fifo_head;
  logic [63:0]          push_data;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic [FIFO_ADDR_W:0] fifo_level;
  logic                 in_bounds;
  logic                 push;
  logic                 pop;
  logic                 start_ok;
  logic                 drain_done;
  logic                 abort_done;

  assign in_bounds  = (pix_x_i < pix_width_i) && (pix_y_i < pix_height_i);
  assign pix_yumi_o = (state == FBW_RUN) && pix_v_i && !fifo_full;
  assign push       = pix_yumi_o && in_bounds;
  assign pop        = mem_v_o && mem_ready_i;
  assign push_data  = {fb_addr(base, stride, pix_x_i, pix_y_i),
                       8'h00, pix_r_i, pix_g_i, pix_b_i};
  assign start_ok   = (state == FBW_IDLE) && cfg_start_i && !cfg_abort_i;

  // No pushes happen in DRAIN/ABORT, so "empty after this edge" only depends
  // on the pop; in ABORT the flush has already cut the buffer to the head.
  assign drain_done = fifo_empty || (pop && (fifo_level == (FIFO_ADDR_W+1)'(1)));
  assign abort_done = fifo_empty || pop;

  assign mem_v_o    = !fifo_empty;
  assign mem_addr_o = fifo_empty ? '0 : fifo_head[63:32];
  assign mem_data_o = fifo_empty ? '0 : fifo_head[31:0];

  jpeg_fb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .AW    (FIFO_ADDR_W),
    .W     (64)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .data_i  (push_data),
    .pop_i   (pop),
    .flush_i (state == FBW_ABORT),
    .data_o  (fifo_head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .level_o (fifo_level)
  );

  // Frame control FSM with registered start/busy/done outputs.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state       <= FBW_IDLE;
      base        <= '0;
      stride      <= '0;
      img_start_o <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
    end else begin
      img_start_o <= 1'b0;
      done_o      <= 1'b0;
      unique case (state)
        FBW_IDLE: begin
          if (start_ok) begin
            base        <= cfg_base_i;
            stride      <= cfg_stride_i;
            state       <= FBW_START;
            img_start_o <= 1'b1;
            busy_o      <= 1'b1;
          end
        end
        FBW_START: begin
          state <= cfg_abort_i ? FBW_ABORT : FBW_WAIT_BUSY;
        end
        FBW_WAIT_BUSY: begin
          if (cfg_abort_i)      state <= FBW_ABORT;
          else if (!img_idle_i) state <= FBW_RUN;
        end
        FBW_RUN: begin
          if (cfg_abort_i)                  state <= FBW_ABORT;
          else if (img_idle_i && !pix_v_i) state <= FBW_DRAIN;
        end
        FBW_DRAIN: begin
          if (cfg_abort_i) begin
            state <= FBW_ABORT;
          end else if (drain_done) begin
            state  <= FBW_IDLE;
            busy_o <= 1'b0;
            done_o <= 1'b1;
          end
        end
        FBW_ABORT: begin
          if (abort_done) begin
            state  <= FBW_IDLE;
            busy_o <= 1'b0;
          end
        end
        default: begin
          state  <= FBW_IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

  // Per-frame write and clip counters, cleared by an accepted start.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_count_o   <= '0;
      drop_count_o <= '0;
    end else if (start_ok) begin
      wr_count_o   <= '0;
      drop_count_o <= '0;
    end else begin
      if (pop)                       wr_count_o   <= wr_count_o + 32'd1;
      if (pix_yumi_o && !in_bounds)  drop_count_o <= drop_count_o + 32'd1;
    end
  end

endmodule

// File: tb/tb_jpeg_fb_writer.sv
// Directed bench for jpeg_fb_writer: full frame, clipped frame, memory stall,
// abort with held head, start during RUN and reset in DRAIN.
module tb_jpeg_fb_writer;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        cfg_start_i, cfg_abort_i;
  logic [31:0] cfg_base_i;
  logic [15:0] cfg_stride_i;
  logic        img_start_o, img_idle_i;
  logic        pix_v_i;
  logic [15:0] pix_x_i, pix_y_i, pix_width_i, pix_height_i;
  logic [7:0]  pix_r_i, pix_g_i, pix_b_i;
  logic        pix_yumi_o, mem_v_o, mem_ready_i;
  logic [31:0] mem_addr_o, mem_data_o;
  logic        busy_o, done_o;
  logic [31:0] wr_count_o, drop_count_o;

  int tests = 0;
  int fails = 0;
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int done_cnt = 0, start_cnt = 0, cyc = 0, last_pop_cyc = 0, done_cyc = 0;
  logic stall_prev = 1'b0;
  logic [31:0] prev_addr = '0, prev_data = '0;

  always #5 clk = ~clk;

  jpeg_fb_writer #(.FIFO_DEPTH(4), .FIFO_ADDR_W(2)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .cfg_start_i(cfg_start_i), .cfg_abort_i(cfg_abort_i),
    .cfg_base_i(cfg_base_i), .cfg_stride_i(cfg_stride_i),
    .img_start_o(img_start_o), .img_idle_i(img_idle_i),
    .pix_v_i(pix_v_i), .pix_x_i(pix_x_i), .pix_y_i(pix_y_i),
    .pix_width_i(pix_width_i), .pix_height_i(pix_height_i),
    .pix_r_i(pix_r_i), .pix_g_i(pix_g_i), .pix_b_i(pix_b_i),
    .pix_yumi_o(pix_yumi_o),
    .mem_v_o(mem_v_o), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_ready_i(mem_ready_i),
    .busy_o(busy_o), .done_o(done_o),
    .wr_count_o(wr_count_o), .drop_count_o(drop_count_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Memory-side monitor: records accepted writes, pulses and request stability.
  always @(negedge clk) begin
    cyc++;
    if (!rst_i) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("hold_v", 32'(mem_v_o), 32'd1);
        check("hold_addr", mem_addr_o, prev_addr);
        check("hold_data", mem_data_o, prev_data);
      end
      if (mem_v_o && mem_ready_i) begin
        wr_addr_q.push_back(mem_addr_o);
        wr_data_q.push_back(mem_data_o);
        last_pop_cyc = cyc;
      end
      if (done_o) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (img_start_o) start_cnt++;
      stall_prev = mem_v_o && !mem_ready_i;
      prev_addr  = mem_addr_o;
      prev_data  = mem_data_o;
    end
  end

  task automatic start_frame(input logic [31:0] base, input logic [15:0] stride,
                             input logic [15:0] w, input logic [15:0] h);
    @(posedge clk); #1;
    cfg_base_i = base; cfg_stride_i = stride;
    pix_width_i = w; pix_height_i = h;
    img_idle_i = 1'b1; cfg_start_i = 1'b1;
    @(posedge clk); #1;
    cfg_start_i = 1'b0; img_idle_i = 1'b0;
    wr_addr_q.delete(); wr_data_q.delete();
    start_cnt = 0; done_cnt = 0;
    @(negedge clk);
    check("img_start", 32'(img_start_o), 32'd1);
    check("busy_start", 32'(busy_o), 32'd1);
    check("wr_clr", wr_count_o, 32'd0);
    check("drop_clr", drop_count_o, 32'd0);
    @(posedge clk);
    @(posedge clk); #1;
  endtask

  // Raster 8x8 block: colour {x, y, 5A}.
  task automatic send_block();
    int  timeouts;
    logic got;
    timeouts = 0;
    for (int i = 0; i < 64; i++) begin
      pix_x_i = 16'(i % 8); pix_y_i = 16'(i / 8);
      pix_r_i = 8'(i % 8);  pix_g_i = 8'(i / 8); pix_b_i = 8'h5A;
      pix_v_i = 1'b1;
      got = 1'b0;
      for (int t = 0; t < 100 && !got; t++) begin
        @(negedge clk);
        got = pix_yumi_o;
        @(posedge clk); #1;
      end
      if (!got) timeouts++;
    end
    pix_v_i = 1'b0;
    check("pix_timeout", 32'(timeouts), 32'd0);
  endtask

  task automatic end_frame();
    img_idle_i = 1'b1;
    for (int t = 0; t < 300 && done_cnt == 0; t++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("done_pulses", 32'(done_cnt), 32'd1);
    check("busy_end", 32'(busy_o), 32'd0);
  endtask

  task automatic check_writes(input logic [31:0] base, input logic [15:0] stride,
                              input int w, input int h);
    int n, bad;
    logic [31:0] ea, ed;
    n = 0; bad = 0;
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++)
        if (x < w && y < h) begin
          ea = base + 32'(y) * 32'(stride) + 32'(x) * 32'd4;
          ed = {8'h00, 8'(x), 8'(y), 8'h5A};
          if (n >= wr_addr_q.size() || wr_addr_q[n] !== ea || wr_data_q[n] !== ed) bad++;
          n++;
        end
    check("wr_num", 32'(wr_addr_q.size()), 32'(n));
    check("wr_seq_bad", 32'(bad), 32'd0);
  endtask

  initial begin
    int yumis, badx;
    rst_i = 1'b0; cfg_start_i = 1'b0; cfg_abort_i = 1'b0;
    cfg_base_i = '0; cfg_stride_i = '0; img_idle_i = 1'b1;
    pix_v_i = 1'b0; pix_x_i = '0; pix_y_i = '0; pix_width_i = '0; pix_height_i = '0;
    pix_r_i = '0; pix_g_i = '0; pix_b_i = '0; mem_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_img_start", 32'(img_start_o), 32'd0);
    check("rst_mem_v", 32'(mem_v_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_wr", wr_count_o, 32'd0);
    check("rst_drop", drop_count_o, 32'd0);
    check("rst_addr", mem_addr_o, 32'd0);
    @(posedge clk); #1;
    rst_i = 1'b1;

    // Full 8x8 frame.
    start_frame(32'h0000_1000, 16'd32, 16'd8, 16'd8);
    send_block();
    end_frame();
    check_writes(32'h0000_1000, 16'd32, 8, 8);
    check("f1_addr0", wr_addr_q[0], 32'h0000_1000);
    check("f1_addr_3_2", wr_addr_q[19], 32'h0000_104C);
    check("f1_data_3_2", wr_data_q[19], 32'h0003_025A);
    check("f1_addr_last", wr_addr_q[63], 32'h0000_10FC);
    check("f1_wr_count", wr_count_o, 32'd64);
    check("f1_drop", drop_count_o, 32'd0);

    // Clipped 5x3 frame, with a start pulse during RUN.
    start_frame(32'h0000_2000, 16'd64, 16'd5, 16'd3);
    cfg_start_i = 1'b1;
    @(posedge clk); #1;
    cfg_start_i = 1'b0;
    send_block();
    end_frame();
    check_writes(32'h0000_2000, 16'd64, 5, 3);
    badx = 0;
    foreach (wr_addr_q[i]) if (((wr_addr_q[i] - 32'h2000) % 64) / 4 >= 5) badx++;
    check("f2_x_clip", 32'(badx), 32'd0);
    check("f2_addr_last", wr_addr_q[14], 32'h0000_2090);
    check("f2_wr_count", wr_count_o, 32'd15);
    check("f2_drop", drop_count_o, 32'd49);
    check("f2_start_pulses", 32'(start_cnt), 32'd1);

    // Memory stall for 20 cycles at frame start.
    start_frame(32'h0000_0000, 16'd32, 16'd8, 16'd8);
    mem_ready_i = 1'b0;
    yumis = 0;
    fork
      send_block();
      begin
        repeat (20) begin
          @(negedge clk);
          if (pix_yumi_o) yumis++;
        end
        @(posedge clk); #1;
        mem_ready_i = 1'b1;
      end
    join
    check("f3_yumi_stall", 32'(yumis), 32'd4);
    end_frame();
    check_writes(32'h0000_0000, 16'd32, 8, 8);
    check("f3_wr_count", wr_count_o, 32'd64);
    check("f3_done_lat", 32'(done_cyc - last_pop_cyc), 32'd1);

    // Abort with head presented and memory stalled.
    start_frame(32'h0000_3000, 16'd32, 16'd8, 16'd8);
    mem_ready_i = 1'b0;
    pix_x_i = 16'd1; pix_y_i = 16'd0; pix_r_i = 8'd1; pix_g_i = 8'd0; pix_b_i = 8'h5A;
    pix_v_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    pix_v_i = 1'b0;
    cfg_abort_i = 1'b1;
    @(posedge clk); #1;
    cfg_abort_i = 1'b0;
    @(negedge clk);
    check("ab_mem_v", 32'(mem_v_o), 32'd1);
    check("ab_head_addr", mem_addr_o, 32'h0000_3004);
    check("ab_busy", 32'(busy_o), 32'd1);
    repeat (4) @(negedge clk);
    check("ab_head_hold", mem_data_o, 32'h0001_005A);
    @(posedge clk); #1;
    mem_ready_i = 1'b1;
    @(posedge clk); #1;
    mem_ready_i = 1'b0;
    @(negedge clk);
    check("ab_mem_v_after", 32'(mem_v_o), 32'd0);
    check("ab_busy_after", 32'(busy_o), 32'd0);
    check("ab_writes", 32'(wr_addr_q.size()), 32'd1);
    check("ab_wr_addr", wr_addr_q[0], 32'h0000_3004);
    repeat (3) @(negedge clk);
    check("ab_no_done", 32'(done_cnt), 32'd0);

    // Frame after abort.
    mem_ready_i = 1'b1;
    start_frame(32'h0000_4000, 16'd16, 16'd2, 16'd1);
    send_block();
    end_frame();
    check_writes(32'h0000_4000, 16'd16, 2, 1);
    check("f5_addr1", wr_addr_q[1], 32'h0000_4004);
    check("f5_drop", drop_count_o, 32'd62);

    // Reset while in DRAIN with pending writes.
    start_frame(32'h0000_5000, 16'd32, 16'd8, 16'd8);
    mem_ready_i = 1'b0;
    pix_x_i = 16'd9; pix_y_i = 16'd0; pix_v_i = 1'b1;
    @(posedge clk); #1;
    pix_x_i = 16'd2; pix_y_i = 16'd1; pix_r_i = 8'd2; pix_g_i = 8'd1;
    repeat (2) @(posedge clk);
    #1;
    pix_v_i = 1'b0; img_idle_i = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("dr_busy", 32'(busy_o), 32'd1);
    check("dr_mem_v", 32'(mem_v_o), 32'd1);
    check("dr_addr", mem_addr_o, 32'h0000_5028);
    check("dr_drop", drop_count_o, 32'd1);
    @(posedge clk); #2;
    rst_i = 1'b0;
    #1;
    check("ar_mem_v", 32'(mem_v_o), 32'd0);
    check("ar_busy", 32'(busy_o), 32'd0);
    check("ar_drop", drop_count_o, 32'd0);
    check("ar_addr", mem_addr_o, 32'd0);
    check("ar_data", mem_data_o, 32'd0);
    check("ar_yumi", 32'(pix_yumi_o), 32'd0);
    mem_ready_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b1;
    start_frame(32'h0000_6000, 16'd32, 16'd8, 16'd8);
    send_block();
    end_frame();
    check_writes(32'h0000_6000, 16'd32, 8, 8);
    check("f6_wr_count", wr_count_o, 32'd64);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/jpeg_fb_writer.md
# jpeg_fb_writer

Frame-level controller that sits after the JPEG output stage. It starts a decode, consumes the decoded pixel stream with a v/yumi handshake, clips padding pixels outside the image, and computes framebuffer addresses. It issues 32-bit pixel writes on a valid/ready memory port and signals completion once the output stage is idle and every write has drained.

## Interface
- FIFO_DEPTH, 4: write-buffer entries (power of 2, ≥2)
- FIFO_ADDR_W, 2: log2(FIFO_DEPTH)
- clk_i  in  1  single clock, rising edge
- rst_i  in  1  reset; asynchronous, active-low
- cfg_start_i  in  1  start pulse; honoured only in IDLE
- cfg_abort_i  in  1  abort request; level, sampled each cycle
- cfg_base_i  in  32  framebuffer byte base address; captured on start
- cfg_stride_i  in  16  line pitch in bytes; captured on start
- img_start_o  out  1  one-cycle flush/start pulse to the decoder and output stage
- img_idle_i  in  1  idle from the output stage
- pix_v_i  in  1  pixel valid
- pix_x_i, pix_y_i  in  16  pixel coordinates
- pix_width_i, pix_height_i  in  16  image dimensions
- pix_r_i, pix_g_i, pix_b_i  in  8  pixel colour
- pix_yumi_o  out  1  pixel consumed this cycle
- mem_v_o  out  1  write request valid
- mem_addr_o  out  32  byte address
- mem_data_o  out  32  {8'h00, r, g, b}
- mem_ready_i  in  1  write accepted
- busy_o  out  1  state ≠ IDLE
- done_o  out  1  one-cycle completion pulse
- wr_count_o  out  32  completed writes this frame
- drop_count_o  out  32  clipped pixels this frame

## Operation
- States (fbw_state_e): IDLE, START, WAIT_BUSY, RUN, DRAIN, ABORT.
- IDLE: cfg_start_i → capture base/stride, clear both counters, go to START.
- START: img_start_o=1 for exactly this cycle → WAIT_BUSY.
- WAIT_BUSY: wait until img_idle_i=0 → RUN.
- RUN: pix_yumi_o = pix_v_i && FIFO not full. For a consumed pixel:
  - If x<width and y<height, push addr = base + y*stride + {x,2'b00}. The arithmetic is 32-bit, and wrap modulo 2^32 is legal.
  - Otherwise drop the pixel and increment drop_count_o. A dropped pixel is still yumi'd.
- RUN → DRAIN when img_idle_i=1 and pix_v_i=0.
- DRAIN: pix_yumi_o=0. When the FIFO is empty → pulse done_o and return to IDLE.
- FIFO head drives mem_v_o/addr/data directly. A pop occurs on mem_v_o && mem_ready_i, and wr_count_o increments on each pop.
- Abort: cfg_abort_i in any non-IDLE state → ABORT.
  - ABORT discards all non-head entries immediately.
  - If the head is presented, it holds until accepted. Then go to IDLE.
  - done_o is not pulsed; counters hold.
- cfg_start_i outside IDLE: ignored. A start and an abort in the same IDLE cycle: abort wins and start is ignored.

## Timing
- Reset values: all outputs 0, state IDLE, FIFO empty, counters 0.
- cfg_start_i at edge N → img_start_o high in cycle N+1.
- Pixel consumed at edge N with FIFO empty → mem_v_o high in cycle N+1.
- Throughput: 1 pixel/cycle while mem_ready_i=1.
- FIFO full: pix_yumi_o=0 even if a pop happens in the same cycle. There is no push-through at full.
- Push and pop in the same cycle when not full: the level is unchanged.
- mem_v_o, once high, stays high with stable addr/data until mem_ready_i. This holds through abort.
- done_o occurs the cycle after the last pop is seen in DRAIN.
- Reset mid-frame: immediate return to reset values with no handshake completion. The memory slave must tolerate a dropped request.

## Structure
- Shared package jpeg_pkg contains:
  - block_type_e and jpeg_format_e (existing)
  - fbw_state_e
  - a PIX_BYTES=4 constant
- Sub-module jpeg_fb_fifo: synchronous show-ahead FIFO, 64-bit {addr,data}, with flush input and level output. The address multiply and FSM live in the top level.

## Test plan
- Start; 8×8 image, base=0x1000, stride=32, 64 pixels, mem_ready_i=1 → 64 writes, pixel (3,2) at 0x104C; done_o one pulse after idle; wr_count_o=64, drop_count_o=0.
- Width=5, height=3, one 8×8 block → 15 writes, drop_count_o=49, no address with x≥5.
- mem_ready_i=0 for 20 cycles mid-frame → yumi stops after 4 pushes; mem_addr_o/mem_data_o stable throughout; no pixel lost after release.
- Abort while the head is presented with mem_ready_i=0 → head held until ready, then IDLE, busy_o=0, no done_o; the next start works.
- Start pulse asserted during RUN → ignored, no second img_start_o.
- Reset asserted mid-DRAIN → all outputs 0 asynchronously; after release, a fresh frame completes correctly.
